stopwatch_ctl: RTL and testbench
================================

# stopwatch_ctl

Sequencing controller for the stopwatch datapath: it turns debounced user buttons (trig, split, init) into a run/pause/split state machine, divides the system clock into count ticks, and drives a four-digit chain of modulo-limited digit incrementors (tenths, seconds-ones, seconds-tens, minutes). It sits between the button debouncers and the seven-segment display driver. It owns the live count, the frozen split snapshot, and the display-source select.

## Interface
- TICK_DIV, 10_000_000: clock cycles per count tick; 0.1 s at 100 MHz; must be ≥ 2.
- L0, 10: limit of digit 0 (tenths).
- L1, 10: limit of digit 1 (seconds ones).
- L2, 6: limit of digit 2 (seconds tens).
- L3, 10: limit of digit 3 (minutes).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trig  in  1  debounced start/stop button level.
- split  in  1  debounced split/unsplit button level.
- init  in  1  debounced clear button level.
- count_en  out  1  high while the counter advances.
- split_en  out  1  high while the display shows the frozen snapshot.
- disp  out  16  display value {d3,d2,d1,d0}, 4 bits per digit: snapshot if split_en, else the live count.
- tick  out  1  one-cycle pulse, registered, high in the cycle after d0 advances.
- wrap  out  1  one-cycle pulse, registered, high in the cycle after the full count wraps 9:59.9 → 0:00.0.

## Operation
- Reset (reset_n low) forces all registers to zero, regardless of clk:
  - state = STOPPED; count_en = 0, split_en = 0.
  - Live digits, snapshot and prescaler = 0.
  - tick = 0, wrap = 0.
  - Edge-detect registers = 0, so an input already high at reset release counts as one event.
- Events: each input is rising-edge detected against its previous-cycle sample. A held level produces exactly one event.
- Priority when events coincide on the same edge:
  - init overrides everything.
  - trig beats split; the split event is dropped.
- init event: state → STOPPED, live digits = 0, prescaler = 0, snapshot = 0.
- States and their outputs (count_en, split_en):
  - STOPPED (0,0).
  - RUNNING (1,0).
  - RUN_SPLIT (1,1).
  - STOP_SPLIT (0,1).
- Transitions on trig:
  - STOPPED ↔ RUNNING.
  - RUN_SPLIT ↔ STOP_SPLIT.
- Transitions on split:
  - RUNNING → RUN_SPLIT, with snapshot capture.
  - RUN_SPLIT → RUNNING.
  - STOP_SPLIT → STOPPED.
  - STOPPED: split is ignored (no transition, no capture).
- Snapshot capture: stores the live digits as held before the capturing edge (pre-increment value, even if a tick lands on that edge).
- Prescaler: counts 0..TICK_DIV-1 only while count_en = 1; when paused it holds its value.
  - At TICK_DIV-1 it returns to 0 and d0 advances.
  - Resuming continues the partial interval.
- Digit chain, per digit: next = value + carry_in.
  - If next ≥ Lk, the digit becomes 0 and carry_out = 1.
  - The carry into d0 is the prescaler wrap; the carry into dk is the carry out of d(k-1).
  - The ripple is combinational within one cycle.
  - Digits never hold values ≥ their limit.
- wrap: set when the carry out of d3 is 1.

## Timing
- Button rising edge sampled at edge k → state, count_en and split_en change after edge k (1-cycle latency from input high).
- Prescaler reaching TICK_DIV-1 at edge k → digits update at edge k. tick (and wrap, if applicable) is high for the cycle after edge k.
- disp is a combinational mux of registers, with no added latency beyond the digit and state registers.
- Entering RUNNING at edge k: the first d0 advance occurs at edge k+TICK_DIV (prescaler at 0).
- Asynchronous reset mid-count returns every output to its reset value immediately. Counting resumes only after a new trig event.
- init while split or running:
  - disp shows 0000 the cycle after.
  - A tick coinciding with init is suppressed.

## Test plan
- TICK_DIV=4. Release reset, trig pulse → count_en=1 next cycle. d0=1 after 4 cycles and tick pulses once; after 40 cycles disp = 16'h0010.
- Run to disp = 16'h9599 (9:59.9), then one more tick → disp = 16'h0000, wrap and tick each high exactly one cycle.
- Running at disp 16'h0003, split → split_en=1 and disp frozen at 0003 while the live count advances. Split again → disp shows the live value (e.g. 0007).
- trig and split rising on the same edge from RUNNING → STOPPED (split dropped), split_en=0, prescaler holds. Resume → next d0 advance after the remaining cycles, not a full 4.
- trig held high for 20 cycles → a single toggle. init during RUN_SPLIT → STOPPED, disp=0000, count_en=0, split_en=0.
- reset_n pulled low mid-count between clock edges → outputs zero immediately. trig held high at release → RUNNING after the first edge.

Source files
------------

// File: rtl/stopwatch_ctl.sv
// stopwatch_ctl: button-driven run/pause/split sequencer with a tick prescaler
// and a four-digit modulo counter chain feeding the display mux.
`default_nettype none

module stopwatch_ctl #(
   parameter int TICK_DIV = 10_000_000,
   parameter int L0       = 10,
   parameter int L1       = 10,
   parameter int L2       = 6,
   parameter int L3       = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        trig,
   input  logic        split,
   input  logic        init,
   output logic        count_en,
   output logic        split_en,
   output logic [15:0] disp,
   output logic        tick,
   output logic        wrap
);

   localparam int            PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_STOPPED    = 2'd0,
      ST_RUNNING    = 2'd1,
      ST_RUN_SPLIT  = 2'd2,
      ST_STOP_SPLIT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          trig_q, split_q, init_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   digits_q, digits_d;
   logic [15:0]   snap_q, snap_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;

   logic          trig_ev, split_ev, init_ev;
   logic          run;
   logic          presc_wrap;
   logic [4:0]    inc0, inc1, inc2, inc3;

   // Returns {carry_out, new_digit}; a digit that would reach its limit rolls to 0.
   function automatic logic [4:0] digit_inc(input logic [3:0] val, input logic cin, input int lim);
      logic [4:0] nxt;
      nxt = {1'b0, val} + {4'b0, cin};
      if (int'(nxt) >= lim) begin
         digit_inc = 5'b1_0000;
      end else begin
         digit_inc = nxt;
      end
   endfunction

   assign trig_ev    = trig  & ~trig_q;
   assign split_ev   = split & ~split_q;
   assign init_ev    = init  & ~init_q;
   assign run        = (state_q == ST_RUNNING) || (state_q == ST_RUN_SPLIT);
   assign presc_wrap = run && (presc_q == PRESC_MAX);

   assign inc0 = digit_inc(digits_q[3:0],   presc_wrap, L0);
   assign inc1 = digit_inc(digits_q[7:4],   inc0[4],    L1);
   assign inc2 = digit_inc(digits_q[11:8],  inc1[4],    L2);
   assign inc3 = digit_inc(digits_q[15:12], inc2[4],    L3);

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      snap_d   = snap_q;
      tick_d   = presc_wrap;
      wrap_d   = inc3[4];

      if (run) begin
         presc_d  = presc_wrap ? '0 : presc_q + PW'(1);
         digits_d = {inc3[3:0], inc2[3:0], inc1[3:0], inc0[3:0]};
      end

      if (init_ev) begin
         state_d  = ST_STOPPED;
         presc_d  = '0;
         digits_d = '0;
         snap_d   = '0;
         tick_d   = 1'b0;
         wrap_d   = 1'b0;
      end else if (trig_ev) begin
         case (state_q)
            ST_STOPPED:    state_d = ST_RUNNING;
            ST_RUNNING:    state_d = ST_STOPPED;
            ST_RUN_SPLIT:  state_d = ST_STOP_SPLIT;
            ST_STOP_SPLIT: state_d = ST_RUN_SPLIT;
            default:       state_d = ST_STOPPED;
         endcase
      end else if (split_ev) begin
         case (state_q)
            ST_RUNNING: begin
               state_d = ST_RUN_SPLIT;
               // Capture the pre-increment count, even when a tick lands on this edge.
               snap_d  = digits_q;
            end
            ST_RUN_SPLIT:  state_d = ST_RUNNING;
            ST_STOP_SPLIT: state_d = ST_STOPPED;
            default:       state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_STOPPED;
         trig_q   <= 1'b0;
         split_q  <= 1'b0;
         init_q   <= 1'b0;
         presc_q  <= '0;
         digits_q <= '0;
         snap_q   <= '0;
         tick_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         trig_q   <= trig;
         split_q  <= split;
         init_q   <= init;
         presc_q  <= presc_d;
         digits_q <= digits_d;
         snap_q   <= snap_d;
         tick_q   <= tick_d;
         wrap_q   <= wrap_d;
      end
   end

   assign count_en = run;
   assign split_en = (state_q == ST_RUN_SPLIT) || (state_q == ST_STOP_SPLIT);
   assign disp     = split_en ? snap_q : digits_q;
   assign tick     = tick_q;
   assign wrap     = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctl.sv
// tb_stopwatch_ctl: directed checks of stopwatch_ctl with a 4-cycle tick.
`default_nettype none

module tb_stopwatch_ctl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trig, split, init;
   logic        count_en, split_en, tick, wrap;
   logic [15:0] disp;

   int n_checks = 0;
   int n_pass   = 0;

   stopwatch_ctl #(
      .TICK_DIV(4), .L0(10), .L1(10), .L2(6), .L3(10)
   ) dut (
      .clk(clk), .reset_n(reset_n), .trig(trig), .split(split), .init(init),
      .count_en(count_en), .split_en(split_en), .disp(disp), .tick(tick), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      trig    = 1'b0;
      split   = 1'b0;
      init    = 1'b0;
      step(3);
      check("rst_count_en", 32'(count_en), 32'd0);
      check("rst_split_en", 32'(split_en), 32'd0);
      check("rst_disp",     32'(disp),     32'h0);
      check("rst_tick",     32'(tick),     32'd0);
      check("rst_wrap",     32'(wrap),     32'd0);

      // Start: trig event on E1, first tick at E5.
      reset_n = 1'b1;
      trig    = 1'b1;
      step(1);
      check("start_count_en", 32'(count_en), 32'd1);
      trig = 1'b0;
      step(3);
      check("pre_tick_disp", 32'(disp), 32'h0);
      check("pre_tick_tick", 32'(tick), 32'd0);
      step(1);
      check("first_tick_disp", 32'(disp), 32'h0001);
      check("first_tick_tick", 32'(tick), 32'd1);
      step(1);
      check("tick_one_cycle", 32'(tick), 32'd0);
      step(35);
      check("ten_ticks_disp", 32'(disp), 32'h0010);

      // 5999th tick reaches 9:59.9; the 6000th wraps.
      step(23956);
      check("max_disp", 32'(disp), 32'h9599);
      check("max_wrap", 32'(wrap), 32'd0);
      step(4);
      check("wrap_disp", 32'(disp), 32'h0000);
      check("wrap_pulse", 32'(wrap), 32'd1);
      check("wrap_tick",  32'(tick), 32'd1);
      step(1);
      check("wrap_one_cycle", 32'(wrap), 32'd0);
      check("tick_low_after_wrap", 32'(tick), 32'd0);

      // Split at live 0003, watch the snapshot stay frozen.
      step(11);
      check("pre_split_disp", 32'(disp), 32'h0003);
      split = 1'b1;
      step(1);
      check("split_en_on", 32'(split_en), 32'd1);
      check("split_disp",  32'(disp),     32'h0003);
      split = 1'b0;
      step(14);
      check("split_frozen",   32'(disp),     32'h0003);
      check("split_counting", 32'(count_en), 32'd1);
      split = 1'b1;   // unsplit on the same edge as a tick
      step(1);
      check("unsplit_en",   32'(split_en), 32'd0);
      check("unsplit_disp", 32'(disp),     32'h0007);
      split = 1'b0;

      // trig and split together: stop, split dropped, prescaler left at 2.
      step(1);
      trig  = 1'b1;
      split = 1'b1;
      step(1);
      check("coinc_count_en", 32'(count_en), 32'd0);
      check("coinc_split_en", 32'(split_en), 32'd0);
      check("coinc_disp",     32'(disp),     32'h0007);
      trig  = 1'b0;
      split = 1'b0;
      step(5);
      check("paused_disp", 32'(disp), 32'h0007);

      // Resume with trig held for 20 cycles; tick after 2 running edges.
      trig = 1'b1;
      step(1);
      check("resume_count_en", 32'(count_en), 32'd1);
      step(1);
      check("resume_partial_disp", 32'(disp), 32'h0007);
      step(1);
      check("resume_tick_disp", 32'(disp), 32'h0008);
      check("resume_tick",      32'(tick), 32'd1);
      step(17);
      check("held_trig_count_en", 32'(count_en), 32'd1);
      check("held_trig_disp",     32'(disp),     32'h0012);

      // init during RUN_SPLIT, coinciding with a tick edge.
      trig  = 1'b0;
      split = 1'b1;
      step(1);
      check("run_split_en", 32'(split_en), 32'd1);
      split = 1'b0;
      step(1);
      init = 1'b1;
      step(1);
      check("init_count_en", 32'(count_en), 32'd0);
      check("init_split_en", 32'(split_en), 32'd0);
      check("init_disp",     32'(disp),     32'h0000);
      check("init_tick_suppressed", 32'(tick), 32'd0);
      init = 1'b0;

      // Async reset mid-count, trig held through release.
      trig = 1'b1;
      step(1);
      check("restart_count_en", 32'(count_en), 32'd1);
      step(4);
      check("pre_areset_disp", 32'(disp), 32'h0001);
      check("pre_areset_tick", 32'(tick), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("areset_count_en", 32'(count_en), 32'd0);
      check("areset_disp",     32'(disp),     32'h0000);
      check("areset_tick",     32'(tick),     32'd0);
      step(1);
      check("areset_hold_disp", 32'(disp), 32'h0000);
      reset_n = 1'b1;
      step(1);
      check("release_held_trig", 32'(count_en), 32'd1);
      step(3);
      check("release_pre_tick", 32'(disp), 32'h0000);
      step(1);
      check("release_first_tick", 32'(disp), 32'h0001);
      trig = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
